// File: rtl/pong_pkg.sv
// Purpose: shared game types, direction encodings and default playfield geometry.
// Latency: n/a (types, constants and a pure helper function only).
// Backpressure: n/a.
//
// The renderer and the controller both import this package so that they
// agree on screen, ball and paddle dimensions.
package pong_pkg;

  // Encodings are visible on the debug LEDs, so they are fixed explicitly.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SERVE = 3'd1,
    ST_PLAY  = 3'd2,
    ST_POINT = 3'd3,
    ST_OVER  = 3'd4
  } game_state_t;

  localparam int DEF_SCREEN_W  = 640;
  localparam int DEF_SCREEN_H  = 480;
  localparam int DEF_BALL_SIZE = 8;
  localparam int DEF_PADDLE_W  = 10;
  localparam int DEF_PADDLE_H  = 60;
  localparam int DEF_P1_X      = 50;
  localparam int DEF_P2_X      = 590;

  localparam logic DIR_RIGHT = 1'b0;
  localparam logic DIR_LEFT  = 1'b1;
  localparam logic DIR_DOWN  = 1'b0;
  localparam logic DIR_UP    = 1'b1;

  // Vertical span test between the ball and a paddle. The operands are
  // 11 bits wide so that y + size can never wrap for 10-bit coordinates.
  function automatic logic span_overlap(input logic [10:0] ball_top,
                                        input logic [10:0] pad_top,
                                        input logic [10:0] ball_size,
                                        input logic [10:0] pad_h);
    return ((ball_top + ball_size) > pad_top) && (ball_top < (pad_top + pad_h));
  endfunction

endpackage

// File: rtl/pong_btn_edge.sv
// Purpose: synchronise an active-low asynchronous pushbutton and emit a press pulse.
// Latency: press_vld is high for one cycle, two to three clocks after the button falls.
// Backpressure: none; a pulse that the consumer does not act on is simply lost.
//
// Ports:
//   vga_clk   in   clock
//   rst       in   synchronous active-high reset (button reads as released)
//   btn_n     in   raw active-low button, asynchronous to vga_clk
//   press_vld out  one-cycle pulse on each high-to-low transition of btn_n
module pong_btn_edge (
  input  logic vga_clk,
  input  logic rst,
  input  logic btn_n,
  output logic press_vld
);

  // sync_q[0], sync_q[1] form the two-flop synchroniser; sync_q[2] holds the
  // previous synchronised level for edge detection.
  logic [2:0] sync_q;

  always_ff @(posedge vga_clk) begin
    if (rst) begin
      sync_q <= 3'b111;
    end else begin
      sync_q <= {sync_q[1:0], btn_n};
    end
  end

  // Falling edge of the synchronised level: it was high, now it is low.
  assign press_vld = sync_q[2] & ~sync_q[1];

endmodule

// File: rtl/pong_game_ctrl.sv
// Purpose: pong game sequencer; owns ball position/velocity and scores, steps once per frame.
// Latency: all outputs registered; a frame_tick or button press is reflected one clock later.
// Backpressure: none; frame_tick and presses are consumed on arrival or ignored by state.
//
// Ports:
//   vga_clk, rst          clock and synchronous active-high reset
//   frame_tick            one-cycle pulse per frame (start of vertical blank)
//   start_n               raw active-low start button (asynchronous)
//   p1_y, p2_y            live top-y of the left / right paddles
//   ball_x, ball_y        ball top-left corner, ball_en ball visible
//   score_p1, score_p2    scores; game_over / winner (0 = P1, 1 = P2)
//   state                 current state encoding for debug LEDs
module pong_game_ctrl
  import pong_pkg::*;
#(
  parameter int SCREEN_W     = DEF_SCREEN_W,
  parameter int SCREEN_H     = DEF_SCREEN_H,
  parameter int BALL_SIZE    = DEF_BALL_SIZE,
  parameter int PADDLE_W     = DEF_PADDLE_W,
  parameter int PADDLE_H     = DEF_PADDLE_H,
  parameter int P1_X         = DEF_P1_X,
  parameter int P2_X         = DEF_P2_X,
  parameter int BALL_SPEED   = 2,
  parameter int WIN_SCORE    = 9,   // at most 15
  parameter int SERVE_FRAMES = 60   // at least 1
) (
  input  logic       vga_clk,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic       start_n,
  input  logic [9:0] p1_y,
  input  logic [9:0] p2_y,
  output logic [9:0] ball_x,
  output logic [9:0] ball_y,
  output logic       ball_en,
  output logic [3:0] score_p1,
  output logic [3:0] score_p2,
  output logic       game_over,
  output logic       winner,
  output logic [2:0] state
);

  localparam int CW = $clog2(SERVE_FRAMES + 1);

  localparam logic [9:0]    CX         = 10'(SCREEN_W / 2 - BALL_SIZE / 2);
  localparam logic [9:0]    CY         = 10'(SCREEN_H / 2 - BALL_SIZE / 2);
  localparam logic [9:0]    SPD10      = 10'(BALL_SPEED);
  localparam logic [10:0]   SPD        = 11'(BALL_SPEED);
  localparam logic [10:0]   Y_MAX      = 11'(SCREEN_H - BALL_SIZE);
  localparam logic [10:0]   FACE_R     = 11'(P2_X - BALL_SIZE);
  localparam logic [10:0]   FACE_L     = 11'(P1_X + PADDLE_W);
  localparam logic [10:0]   BSZ        = 11'(BALL_SIZE);
  localparam logic [10:0]   PH         = 11'(PADDLE_H);
  localparam logic [3:0]    WIN        = 4'(WIN_SCORE);
  localparam logic [CW-1:0] SERVE_INIT = CW'(SERVE_FRAMES);

  game_state_t   st;
  logic          dx;
  logic          dy;
  logic [CW-1:0] serve_cnt;
  logic          scorer;     // 0 = P1 scored, 1 = P2 scored
  logic          press_vld;

  pong_btn_edge u_start (
    .vga_clk   (vga_clk),
    .rst       (rst),
    .btn_n     (start_n),
    .press_vld (press_vld)
  );

  // Next-frame candidates, computed every cycle but only committed on a
  // frame_tick while in PLAY. 11-bit arithmetic keeps every sum wrap-free.
  logic [10:0] x_w;
  logic [10:0] y_w;
  logic [10:0] y_new;
  logic        dy_new;
  logic        at_right;
  logic        at_left;
  logic        hit_r;
  logic        hit_l;
  logic [3:0]  sc_next;

  assign x_w = {1'b0, ball_x};
  assign y_w = {1'b0, ball_y};

  always_comb begin
    y_new  = y_w;
    dy_new = dy;
    if (dy == DIR_DOWN) begin
      if (y_w + SPD >= Y_MAX) begin
        y_new  = Y_MAX;
        dy_new = DIR_UP;
      end else begin
        y_new = y_w + SPD;
      end
    end else begin
      if (y_w <= SPD) begin
        y_new  = '0;
        dy_new = DIR_DOWN;
      end else begin
        y_new = y_w - SPD;
      end
    end
  end

  // Paddle overlap is judged against the ball's post-move y.
  assign at_right = (x_w + SPD) >= FACE_R;
  assign at_left  = x_w <= (FACE_L + SPD);
  assign hit_r    = span_overlap(y_new, {1'b0, p2_y}, BSZ, PH);
  assign hit_l    = span_overlap(y_new, {1'b0, p1_y}, BSZ, PH);
  assign sc_next  = (scorer ? score_p2 : score_p1) + 4'd1;

  assign state = st;

  always_ff @(posedge vga_clk) begin
    if (rst) begin
      st        <= ST_IDLE;
      ball_x    <= CX;
      ball_y    <= CY;
      ball_en   <= 1'b0;
      score_p1  <= '0;
      score_p2  <= '0;
      game_over <= 1'b0;
      winner    <= 1'b0;
      dx        <= DIR_RIGHT;
      dy        <= DIR_DOWN;
      serve_cnt <= '0;
      scorer    <= 1'b0;
    end else begin
      case (st)
        ST_IDLE: begin
          if (press_vld) begin
            ball_x    <= CX;
            ball_y    <= CY;
            serve_cnt <= SERVE_INIT;
            ball_en   <= 1'b1;
            st        <= ST_SERVE;
          end
        end

        ST_SERVE: begin
          // The tick that empties the counter only starts play; the ball
          // first moves on the following tick.
          if (frame_tick) begin
            serve_cnt <= serve_cnt - CW'(1);
            if (serve_cnt == CW'(1)) begin
              st <= ST_PLAY;
            end
          end
        end

        ST_PLAY: begin
          if (frame_tick) begin
            ball_y <= y_new[9:0];
            dy     <= dy_new;
            if (dx == DIR_RIGHT) begin
              if (!at_right) begin
                ball_x <= ball_x + SPD10;
              end else if (hit_r) begin
                ball_x <= FACE_R[9:0];
                dx     <= DIR_LEFT;
              end else begin
                scorer  <= 1'b0;
                ball_en <= 1'b0;
                st      <= ST_POINT;
              end
            end else begin
              if (!at_left) begin
                ball_x <= ball_x - SPD10;
              end else if (hit_l) begin
                ball_x <= FACE_L[9:0];
                dx     <= DIR_RIGHT;
              end else begin
                scorer  <= 1'b1;
                ball_en <= 1'b0;
                st      <= ST_POINT;
              end
            end
          end
        end

        ST_POINT: begin
          if (scorer) begin
            score_p2 <= sc_next;
          end else begin
            score_p1 <= sc_next;
          end
          if (sc_next == WIN) begin
            game_over <= 1'b1;
            winner    <= scorer;
            st        <= ST_OVER;
          end else begin
            // Serve toward the player who just conceded.
            ball_x    <= CX;
            ball_y    <= CY;
            dx        <= scorer ? DIR_LEFT : DIR_RIGHT;
            serve_cnt <= SERVE_INIT;
            ball_en   <= 1'b1;
            st        <= ST_SERVE;
          end
        end

        ST_OVER: begin
          if (press_vld) begin
            score_p1  <= '0;
            score_p2  <= '0;
            game_over <= 1'b0;
            dx        <= DIR_RIGHT;
            ball_x    <= CX;
            ball_y    <= CY;
            serve_cnt <= SERVE_INIT;
            ball_en   <= 1'b1;
            st        <= ST_SERVE;
          end
        end

        default: st <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Purpose: self-checking bench for pong_game_ctrl against a frame-level game model.
// Latency: outputs are checked every clock, half a period after the active edge.
// Backpressure: n/a.
module tb_pong_game_ctrl;

  localparam int SF   = 3;
  localparam int WIN  = 2;
  localparam int CX   = 640 / 2 - 8 / 2;
  localparam int CY   = 480 / 2 - 8 / 2;
  localparam int YMAX = 480 - 8;
  localparam int FR   = 590 - 8;
  localparam int FL   = 50 + 10;
  localparam int SPD  = 2;

  localparam int PH_IDLE  = 0;
  localparam int PH_SERVE = 1;
  localparam int PH_PLAY  = 2;
  localparam int PH_POINT = 3;
  localparam int PH_OVER  = 4;

  logic       vga_clk = 1'b0;
  logic       rst;
  logic       frame_tick;
  logic       start_n;
  logic [9:0] p1_y;
  logic [9:0] p2_y;
  logic [9:0] ball_x;
  logic [9:0] ball_y;
  logic       ball_en;
  logic [3:0] score_p1;
  logic [3:0] score_p2;
  logic       game_over;
  logic       winner;
  logic [2:0] state;

  pong_game_ctrl #(
    .SERVE_FRAMES (SF),
    .WIN_SCORE    (WIN)
  ) dut (
    .vga_clk    (vga_clk),
    .rst        (rst),
    .frame_tick (frame_tick),
    .start_n    (start_n),
    .p1_y       (p1_y),
    .p2_y       (p2_y),
    .ball_x     (ball_x),
    .ball_y     (ball_y),
    .ball_en    (ball_en),
    .score_p1   (score_p1),
    .score_p2   (score_p2),
    .game_over  (game_over),
    .winner     (winner),
    .state      (state)
  );

  always #5 vga_clk = ~vga_clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Game model: phase, position, velocity (+1/-1 per axis), serve count,
  // scores, winner (0/1) and last scorer (1 = P1, 2 = P2).
  int m_ph, m_x, m_y, m_vx, m_vy, m_cnt, m_sc1, m_sc2, m_win, m_scorer;
  // start_n as seen at the last three clock edges (h1 newest).
  int h1, h2, h3;

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic m_reset();
    m_ph = PH_IDLE; m_x = CX; m_y = CY; m_vx = 1; m_vy = 1; m_cnt = 0;
    m_sc1 = 0; m_sc2 = 0; m_win = 0; m_scorer = 0;
    h1 = 1; h2 = 1; h3 = 1;
  endtask

  task automatic m_serve();
    m_x = CX; m_y = CY; m_cnt = SF; m_ph = PH_SERVE;
  endtask

  function automatic bit overlap(input int y, input int py);
    return (y + 8 > py) && (y < py + 60);
  endfunction

  // One frame of play: move, clamp at walls/faces and reflect.
  task automatic m_play();
    int ny, nx;
    ny = m_y + SPD * m_vy;
    if (m_vy > 0 && ny >= YMAX) begin ny = YMAX; m_vy = -1; end
    else if (m_vy < 0 && ny <= 0) begin ny = 0; m_vy = 1; end
    nx = m_x + SPD * m_vx;
    if (m_vx > 0 && nx >= FR) begin
      if (overlap(ny, int'(p2_y))) begin nx = FR; m_vx = -1; end
      else begin nx = m_x; m_scorer = 1; m_ph = PH_POINT; end
    end else if (m_vx < 0 && nx <= FL) begin
      if (overlap(ny, int'(p1_y))) begin nx = FL; m_vx = 1; end
      else begin nx = m_x; m_scorer = 2; m_ph = PH_POINT; end
    end
    m_x = nx;
    m_y = ny;
  endtask

  // Model of one clock edge. The button is seen two edges late, and a
  // press is a released-then-pressed pair in that delayed view.
  task automatic m_edge();
    bit press;
    press = (h3 == 1) && (h2 == 0);
    h3 = h2; h2 = h1; h1 = int'(start_n);
    if (rst) begin
      m_reset();
    end else begin
      case (m_ph)
        PH_IDLE: if (press) m_serve();
        PH_SERVE: if (frame_tick) begin
          m_cnt--;
          if (m_cnt == 0) m_ph = PH_PLAY;
        end
        PH_PLAY: if (frame_tick) m_play();
        PH_POINT: begin
          if (m_scorer == 1) m_sc1++; else m_sc2++;
          if (m_sc1 == WIN || m_sc2 == WIN) begin
            m_ph = PH_OVER;
            m_win = (m_scorer == 2) ? 1 : 0;
          end else begin
            m_vx = (m_scorer == 1) ? 1 : -1;
            m_serve();
          end
        end
        PH_OVER: if (press) begin
          m_sc1 = 0; m_sc2 = 0; m_vx = 1;
          m_serve();
        end
        default: m_ph = PH_IDLE;
      endcase
    end
  endtask

  task automatic compare_all();
    chk("state", int'(state), m_ph);
    chk("ball_x", int'(ball_x), m_x);
    chk("ball_y", int'(ball_y), m_y);
    chk("ball_en", int'(ball_en), int'(m_ph == PH_SERVE || m_ph == PH_PLAY));
    chk("score_p1", int'(score_p1), m_sc1);
    chk("score_p2", int'(score_p2), m_sc2);
    chk("game_over", int'(game_over), int'(m_ph == PH_OVER));
    if (m_ph == PH_OVER) chk("winner", int'(winner), m_win);
  endtask

  task automatic step();
    @(posedge vga_clk);
    m_edge();
    @(negedge vga_clk);
    compare_all();
  endtask

  task automatic tick();
    frame_tick = 1'b1; step();
    frame_tick = 1'b0; step();
  endtask

  task automatic press_btn();
    start_n = 1'b0;
    repeat (3) step();
    start_n = 1'b1;
    step();
  endtask

  function automatic logic [9:0] rand_paddle();
    int p;
    if ($urandom_range(0, 9) < 7) p = m_y + 10 - int'($urandom_range(0, 75));
    else p = int'($urandom_range(0, 420));
    if (p < 0) p = 0;
    return 10'(p);
  endfunction

  initial begin
    rst = 1'b1; frame_tick = 1'b0; start_n = 1'b1; p1_y = '0; p2_y = 10'd420;
    m_reset();
    step(); step();
    rst = 1'b0;
    step();
    chk("rst_state", int'(state), 0);
    chk("rst_ball_en", int'(ball_en), 0);

    // Serve with right paddle parked at 420.
    press_btn();
    chk("serve_state", int'(state), 1);
    chk("serve_en", int'(ball_en), 1);
    tick(); tick();
    chk("serve_hold", int'(state), 1);
    tick();
    chk("play_entry", int'(state), 2);
    chk("play_entry_x", int'(ball_x), 316);
    chk("play_entry_y", int'(ball_y), 236);
    tick();
    chk("first_move_x", int'(ball_x), 318);
    chk("first_move_y", int'(ball_y), 238);
    for (int k = 2; k <= 134; k++) begin
      tick();
      if (k == 118) chk("wall_y", int'(ball_y), 472);
      if (k == 119) chk("wall_back_y", int'(ball_y), 470);
      if (k == 133) begin
        chk("paddle_x", int'(ball_x), 582);
        chk("paddle_y", int'(ball_y), 442);
      end
      if (k == 134) begin
        chk("return_x", int'(ball_x), 580);
        chk("return_y", int'(ball_y), 440);
        chk("return_s1", int'(score_p1), 0);
      end
    end

    // Reset in the middle of play.
    rst = 1'b1; step();
    chk("midrst_state", int'(state), 0);
    chk("midrst_x", int'(ball_x), 316);
    chk("midrst_y", int'(ball_y), 236);
    chk("midrst_en", int'(ball_en), 0);
    rst = 1'b0; step();

    // Right paddle out of the way: P1 scores on the 133rd play tick.
    p2_y = '0;
    press_btn();
    repeat (SF) tick();
    repeat (132) tick();
    frame_tick = 1'b1; step();
    chk("miss_state", int'(state), 3);
    chk("miss_en", int'(ball_en), 0);
    frame_tick = 1'b0; step();
    chk("point_s1", int'(score_p1), 1);
    chk("point_state", int'(state), 1);
    chk("point_x", int'(ball_x), 316);
    chk("point_y", int'(ball_y), 236);
    repeat (SF + 1) tick();
    chk("reserve_dir_x", int'(ball_x), 318);

    // P2 always returns, P1 always misses, until P2 wins.
    for (int t = 0; t < 3000 && m_ph != PH_OVER; t++) begin
      p2_y = 10'((m_y >= 20) ? m_y - 20 : 0);
      p1_y = 10'((m_y < 240) ? 400 : 0);
      tick();
    end
    chk("win_over", int'(game_over), 1);
    chk("win_who", int'(winner), 1);
    chk("win_s2", int'(score_p2), 2);
    chk("win_s1", int'(score_p1), 1);

    // Restart press arriving on the same edge as a frame tick.
    start_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      frame_tick = (h3 == 1) && (h2 == 0);
      step();
    end
    frame_tick = 1'b0;
    start_n = 1'b1;
    chk("restart_state", int'(state), 1);
    chk("restart_s1", int'(score_p1), 0);
    chk("restart_s2", int'(score_p2), 0);
    chk("restart_over", int'(game_over), 0);

    // Random ticks, paddles, presses and occasional resets.
    for (int c = 0; c < 15000; c++) begin
      rst        = ($urandom_range(0, 2999) == 0);
      frame_tick = ($urandom_range(0, 2) == 0);
      start_n    = ($urandom_range(0, 40) != 0);
      if (frame_tick) begin
        p1_y = rand_paddle();
        p2_y = rand_paddle();
      end
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
